// File: rtl/mem_access_unit_if.sv
// Pipeline/memory bus of the MEM-stage load/store unit.
// slave: the load/store unit. master: pipeline plus data memory.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_rd;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] load_data;
  logic        stall;
  logic        exc;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output mem_a, mem_wd, mem_we, load_data, stall, exc
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  mem_a, mem_wd, mem_we, load_data, stall, exc
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte-address to word-index translation, load
// lane extraction/extension, and a two-cycle read-modify-write for SB/SH.
// Optional macro LSU_ALIGN_CHECK_EN enables alignment and range faults.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  localparam int unsigned IDX_W = 30;

  typedef enum logic {IDLE, MERGE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        word_q, word_d;

  logic [IDX_W-1:0]   idx_c;
  logic               fault_c;
  logic [7:0]         lane_b_c;
  logic [15:0]        lane_h_c;
  logic [31:0]        ext_c;
  logic [31:0]        merged_c;

  logic [31:0]        mem_a_c, mem_wd_c, load_data_c;
  logic               mem_we_c, stall_c, exc_c;

  assign idx_c = bus.req_addr[31:2];

`ifdef LSU_ALIGN_CHECK_EN
  // Misaligned half/word or index beyond the memory is a fault.
  assign fault_c = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00)) ||
                   (32'(idx_c) >= MEM_WORDS);
`else
  // Range is only enforced when checking is built in.
  logic unused_range_c;
  assign unused_range_c = (32'(idx_c) >= MEM_WORDS);
  assign fault_c = 1'b0;
`endif

  // Load lane select and sign/zero extension; halves use addr[1] only.
  always_comb begin
    lane_b_c = bus.mem_rd[{bus.req_addr[1:0], 3'b000} +: 8];
    lane_h_c = bus.mem_rd[{bus.req_addr[1], 4'b0000} +: 16];
    ext_c    = bus.mem_rd;
    if (bus.req_size == 2'b00)
      ext_c = bus.req_unsigned ? {24'h0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
    else if (bus.req_size == 2'b01)
      ext_c = bus.req_unsigned ? {16'h0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
  end

  // Current memory word with the addressed store lane replaced.
  always_comb begin
    merged_c = bus.mem_rd;
    if (bus.req_size == 2'b00)
      merged_c[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
    else
      merged_c[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    mem_a_c     = '0;
    mem_wd_c    = '0;
    mem_we_c    = 1'b0;
    load_data_c = '0;
    stall_c     = 1'b0;
    exc_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mem_a_c = 32'(idx_c);
          if (fault_c) begin
            exc_c = 1'b1;
          end else if (!bus.req_we) begin
            load_data_c = ext_c;
          end else if (bus.req_size[1]) begin
            mem_wd_c = bus.req_wdata;
            mem_we_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            idx_d   = idx_c;
            word_d  = merged_c;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        mem_a_c  = 32'(idx_q);
        mem_wd_c = word_q;
        mem_we_c = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and held merge registers; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  assign bus.mem_a     = mem_a_c;
  assign bus.mem_wd    = mem_wd_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.load_data = load_data_c;
  assign bus.stall     = stall_c;
  assign bus.exc       = exc_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 100-word memory.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mem [0:99];

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Combinational read, write on rising edge.
  assign bus.mem_rd = (bus.mem_a < 32'd100) ? mem[bus.mem_a[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_we && (bus.mem_a < 32'd100))
      mem[bus.mem_a[6:0]] <= bus.mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request shortly after the rising edge, then settle.
  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 100; i++) mem[i] = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset state
    #3;
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wd", bus.mem_wd, 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_load", bus.load_data, 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_exc", 32'(bus.exc), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // SW 0xDEADBEEF @0x8
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    chk("sw_mem_a", bus.mem_a, 32'd2);
    chk("sw_mem_we", 32'(bus.mem_we), 32'h1);
    chk("sw_mem_wd", bus.mem_wd, 32'hDEADBEEF);
    chk("sw_stall", 32'(bus.stall), 32'h0);
    idle();
    chk("sw_we_one_cycle", 32'(bus.mem_we), 32'h0);
    chk("sw_committed", mem[2], 32'hDEADBEEF);

    // Loads from word 2
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    chk("lw", bus.load_data, 32'hDEADBEEF);
    chk("lw_no_we", 32'(bus.mem_we), 32'h0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
    chk("lb", bus.load_data, 32'hFFFFFFBE);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
    chk("lbu", bus.load_data, 32'h000000BE);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
    chk("lh", bus.load_data, 32'hFFFFDEAD);
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
    chk("lhu", bus.load_data, 32'h0000DEAD);
    chk("lhu_stall", 32'(bus.stall), 32'h0);

    // SB 0x12 @0xA: stall cycle then merge-write cycle
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'hA, 32'h12);
    chk("sb_c1_stall", 32'(bus.stall), 32'h1);
    chk("sb_c1_we", 32'(bus.mem_we), 32'h0);
    chk("sb_c1_mem_a", bus.mem_a, 32'd2);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'hA, 32'h12);
    chk("sb_c2_we", 32'(bus.mem_we), 32'h1);
    chk("sb_c2_wd", bus.mem_wd, 32'hDE12BEEF);
    chk("sb_c2_stall", 32'(bus.stall), 32'h0);
    chk("sb_c2_exc", 32'(bus.exc), 32'h0);

    // SH 0x3344 @0x8 immediately after
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h8, 32'h3344);
    chk("sh_c1_stall", 32'(bus.stall), 32'h1);
    chk("sh_c1_we", 32'(bus.mem_we), 32'h0);
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h8, 32'h3344);
    chk("sh_c2_wd", bus.mem_wd, 32'hDE123344);
    chk("sh_c2_we", 32'(bus.mem_we), 32'h1);

    // Load right after MERGE sees merged word
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    chk("ld_after_merge", bus.load_data, 32'hDE123344);
    chk("ld_after_merge_stall", 32'(bus.stall), 32'h0);

    // Word 1 preload
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344);
    idle();
    chk("w1_committed", mem[1], 32'h11223344);

`ifdef LSU_ALIGN_CHECK_EN
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    chk("chk_lw6_exc", 32'(bus.exc), 32'h1);
    chk("chk_lw6_load", bus.load_data, 32'h0);
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h1, 32'hBEEF);
    chk("chk_sh1_exc", 32'(bus.exc), 32'h1);
    chk("chk_sh1_we", 32'(bus.mem_we), 32'h0);
    chk("chk_sh1_stall", 32'(bus.stall), 32'h0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h190, 32'h0);
    chk("chk_range_exc", 32'(bus.exc), 32'h1);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h18C, 32'h0);
    chk("chk_last_word_exc", 32'(bus.exc), 32'h0);
    idle();
    chk("chk_no_merge_we", 32'(bus.mem_we), 32'h0);
    chk("chk_mem0", mem[0], 32'h0);
`else
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    chk("nochk_lw6_exc", 32'(bus.exc), 32'h0);
    chk("nochk_lw6_mem_a", bus.mem_a, 32'd1);
    chk("nochk_lw6_load", bus.load_data, 32'h11223344);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'hB, 32'h0);
    chk("nochk_lh_odd", bus.load_data, 32'hFFFFDE12);
`endif

    // Reset during MERGE drops the write immediately
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h8, 32'hAA);
    chk("rm_c1_stall", 32'(bus.stall), 32'h1);
    @(posedge clk); #1;
    chk("rm_merge_we", 32'(bus.mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rm_we_drop", 32'(bus.mem_we), 32'h0);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rm_mem_unchanged", mem[2], 32'hDE123344);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    chk("rm_reload", bus.load_data, 32'hDE123344);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit sitting directly upstream of the word-addressed data memory in the MEM stage of the 5-stage MiniMIPS pipeline. Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests from the EX/MEM register into word-indexed memory accesses:
- Lane extraction and sign extension for loads.
- A registered two-cycle read-modify-write for sub-word stores, stalling the pipeline for one cycle.
- Optional alignment and range trapping.

## Interface
- MEM_WORDS, 100: number of 32-bit words in the data memory; word index range is 0..MEM_WORDS-1.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  EX/MEM holds a memory operation this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half taken from low bits.
- mem_rd  in  32  combinational read data from data memory.
- mem_a  out  32  word index to data memory.
- mem_wd  out  32  write data to data memory.
- mem_we  out  1  write enable to data memory.
- load_data  out  32  aligned, extended load result to MEM/WB.
- stall  out  1  hold IF/ID/EX and EX/MEM this cycle.
- exc  out  1  access fault for the current request.

## Operation
- Little-endian lanes: byte k of a word is at bits 8k+7:8k; half h is at bits 16h+15:16h.
- States: IDLE, MERGE. Reset: IDLE, held index/word registers 0.
- When req_valid=0 in IDLE: mem_a=0, mem_wd=0, mem_we=0, load_data=0, stall=0, exc=0.
- IDLE behaviour by request type:
  - Load: mem_a = req_addr[31:2]. load_data = the selected lane of mem_rd, extended per req_unsigned; word loads pass mem_rd through. No stall, no write.
  - Word store: mem_a = req_addr[31:2], mem_wd = req_wdata, mem_we = 1. Stays in IDLE.
  - Byte/half store:
    - mem_a = req_addr[31:2], mem_we = 0, stall = 1.
    - Register the index, and mem_rd with the addressed lane replaced by req_wdata[7:0] or req_wdata[15:0].
    - Go to MERGE.
- MERGE:
  - mem_a = held index, mem_wd = held merged word, mem_we = 1, stall = 0. Request inputs are ignored.
  - Unconditionally return to IDLE; the next request is accepted the following cycle.
- Reset asserted in MERGE: the state returns to IDLE immediately and the pending write is dropped (mem_we falls asynchronously).
- Upstream holds all req_* inputs stable while stall=1.

## Timing
- Loads: zero added cycles; load_data is combinational from req_addr through memory.
- Word store: commits at the rising edge ending the request cycle.
- Sub-word store: two cycles. stall=1 in cycle 1; the write commits at the edge ending cycle 2 (MERGE).
- Back-to-back sub-word stores: each takes 2 cycles; a store to the same word in the next instruction sees the merged value, because the read occurs after the previous commit.
- exc is combinational, valid in the request cycle only; never asserted in MERGE.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - A fault is any of the following: a halfword with addr[0]=1, a word with addr[1:0]!=0, or req_addr[31:2] >= MEM_WORDS.
  - On a fault: exc=1, mem_we=0, load_data=0, stall=0, and no MERGE entry.
- LSU_ALIGN_CHECK_EN undefined:
  - exc is tied 0.
  - Halfword ignores addr[0]; word ignores addr[1:0].
  - No range check; the index passes through unchanged.

## Test plan
- Reset → all outputs 0, state IDLE; then assert rst_n low during MERGE → mem_we drops to 0 immediately and memory is unchanged.
- SW 0xDEADBEEF @0x8 → mem_a=2, mem_we=1 for one cycle, no stall. Then LW @0x8 → load_data=0xDEADBEEF.
- Word 2 = 0xDEADBEEF, LB @0x9 → 0xFFFFFFBE. LBU @0x9 → 0x000000BE. LH @0xA → 0xFFFFDEAD. LHU @0xA → 0x0000DEAD.
- Word 2 = 0xDEADBEEF, SB 0x12 @0xA:
  - Cycle 1: stall=1, mem_we=0.
  - Cycle 2: mem_we=1, mem_wd=0xDE12BEEF.
  - Follow with SH 0x3344 @0x8 → final word 0xDE123344.
- With LSU_ALIGN_CHECK_EN:
  - LW @0x6 → exc=1, load_data=0.
  - SH @0x1 → exc=1, no write.
  - LW @0x190 (index 100) → exc=1.
  - Without the macro, LW @0x6 reads word 1 and exc=0.
- Load issued the cycle after a MERGE to the same word → returns the merged value, no extra stall.
